// File: rtl/mmio_io_hub_if.sv
// CPU data-port / BRAM port-A bundle seen by the I/O hub.
// The master side drives the address, write and BRAM read data; the hub answers on the slave side.
interface mmio_io_hub_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_we;
  logic [WIDTH-1:0]      rdata;
  logic                  io_sel;

  modport master (output addr, we, wdata, mem_rdata, input rdata, mem_we, io_sel);
  modport slave  (input addr, we, wdata, mem_rdata, output rdata, mem_we, io_sel);
endinterface

// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: output registers, debounced switches with rising-edge
// pending flags and maskable irq, plus a loadable free-running timer.
module mmio_io_hub #(
  parameter int WIDTH           = 16,
  parameter int ADDR_WIDTH      = 10,
  parameter int NUM_OUT         = 2,
  parameter int OUT_WIDTH       = 8,
  parameter int IN_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  mmio_io_hub_if.slave                 bus,
  input  logic [IN_WIDTH-1:0]          switches,
  output logic [NUM_OUT*OUT_WIDTH-1:0] out_ports,
  output logic                         irq
);
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]                          off;
  logic                                io_wr;
  logic [NUM_OUT-1:0][OUT_WIDTH-1:0]   out_q;
  logic [IN_WIDTH-1:0]                 sync1, sync, stable, pend, mask;
  logic [IN_WIDTH-1:0]                 rise, w1c;
  logic [CW-1:0]                       cnt;
  logic                                accept;
  logic [WIDTH-1:0]                    timer;

  assign off         = bus.addr[3:0];
  assign bus.io_sel  = bus.addr[ADDR_WIDTH-1] & bus.addr[ADDR_WIDTH-2];
  assign bus.mem_we  = bus.we & ~bus.io_sel;
  assign io_wr       = bus.we & bus.io_sel;
  assign out_ports   = out_q;
  assign irq         = |(pend & mask);

  // A switch change is taken only after sync has differed from stable for
  // DEBOUNCE_CYCLES consecutive edges; the accept edge is the last of them.
  assign accept = (sync != stable) && (cnt == CNT_LAST);
  assign rise   = accept ? (sync & ~stable) : '0;
  assign w1c    = (io_wr && off == 4'h9) ? bus.wdata[IN_WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++)
        if (io_wr && off == 4'(k)) out_q[k] <= bus.wdata[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync   <= '0;
      stable <= '0;
      cnt    <= '0;
      pend   <= '0;
      mask   <= '0;
      timer  <= '0;
    end else begin
      sync1 <= switches;
      sync  <= sync1;
      if (sync == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      // A new edge beats a simultaneous write-one-to-clear on the same bit.
      pend <= (pend & ~w1c) | rise;
      if (io_wr && off == 4'hA) mask <= bus.wdata[IN_WIDTH-1:0];
      timer <= (io_wr && off == 4'hC) ? bus.wdata : timer + WIDTH'(1);
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (!bus.io_sel) begin
      bus.rdata = bus.mem_rdata;
    end else begin
      for (int k = 0; k < NUM_OUT; k++)
        if (off == 4'(k)) bus.rdata[OUT_WIDTH-1:0] = out_q[k];
      case (off)
        4'h8:    bus.rdata[IN_WIDTH-1:0] = stable;
        4'h9:    bus.rdata[IN_WIDTH-1:0] = pend;
        4'hA:    bus.rdata[IN_WIDTH-1:0] = mask;
        4'hC:    bus.rdata = timer;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed bench for mmio_io_hub with a cycle-level reference model of the register map.
module tb_mmio_io_hub;
  localparam int WIDTH = 16, ADDR_WIDTH = 10, NUM_OUT = 2, OUT_WIDTH = 8, IN_WIDTH = 8, DEB = 16;

  logic clk = 1'b0;
  logic reset;
  logic [IN_WIDTH-1:0]          switches;
  logic [NUM_OUT*OUT_WIDTH-1:0] out_ports;
  logic                         irq;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  mmio_io_hub_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  mmio_io_hub #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_OUT(NUM_OUT), .OUT_WIDTH(OUT_WIDTH),
                .IN_WIDTH(IN_WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .bus(bus), .switches(switches), .out_ports(out_ports), .irq(irq));

  always #5 clk = ~clk;

  // Reference model: register contents plus a run-length view of the switch debounce.
  logic [OUT_WIDTH-1:0] m_out [NUM_OUT];
  logic [IN_WIDTH-1:0]  m_s1, m_s2, m_stable, m_pend, m_mask;
  logic [WIDTH-1:0]     m_timer;
  int                   m_run;
  logic                 m_io;
  logic [3:0]           m_off;
  logic [IN_WIDTH-1:0]  m_new_rise, m_clr;

  assign m_io       = bus.addr[ADDR_WIDTH-1] & bus.addr[ADDR_WIDTH-2];
  assign m_off      = bus.addr[3:0];
  assign m_new_rise = (m_s2 != m_stable && m_run + 1 == DEB) ? (m_s2 & ~m_stable) : '0;
  assign m_clr      = (m_io && bus.we && m_off == 4'h9) ? bus.wdata[IN_WIDTH-1:0] : '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_OUT; k++) m_out[k] <= '0;
      m_s1 <= '0; m_s2 <= '0; m_stable <= '0; m_pend <= '0; m_mask <= '0;
      m_timer <= '0; m_run <= 0;
    end else begin
      m_s1 <= switches;
      m_s2 <= m_s1;
      if (m_s2 == m_stable) m_run <= 0;
      else if (m_run + 1 == DEB) begin m_stable <= m_s2; m_run <= 0; end
      else m_run <= m_run + 1;
      m_pend  <= (m_pend & ~m_clr) | m_new_rise;
      m_timer <= m_timer + 16'd1;
      if (m_io && bus.we) begin
        for (int k = 0; k < NUM_OUT; k++) if (int'(m_off) == k) m_out[k] <= bus.wdata[OUT_WIDTH-1:0];
        if (m_off == 4'hA) m_mask <= bus.wdata[IN_WIDTH-1:0];
        if (m_off == 4'hC) m_timer <= bus.wdata;
      end
    end
  end

  function automatic logic [WIDTH-1:0] exp_rdata();
    logic [WIDTH-1:0] r = '0;
    if (!m_io) return bus.mem_rdata;
    if (int'(m_off) < NUM_OUT) r[OUT_WIDTH-1:0] = m_out[int'(m_off)];
    else if (m_off == 4'h8) r[IN_WIDTH-1:0] = m_stable;
    else if (m_off == 4'h9) r[IN_WIDTH-1:0] = m_pend;
    else if (m_off == 4'hA) r[IN_WIDTH-1:0] = m_mask;
    else if (m_off == 4'hC) r = m_timer;
    return r;
  endfunction

  function automatic logic [NUM_OUT*OUT_WIDTH-1:0] exp_ports();
    logic [NUM_OUT*OUT_WIDTH-1:0] p;
    for (int k = 0; k < NUM_OUT; k++) p[k*OUT_WIDTH +: OUT_WIDTH] = m_out[k];
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_rdata", 32'(bus.rdata), 32'(exp_rdata()));
      chk("cyc_io_sel", 32'(bus.io_sel), 32'(m_io));
      chk("cyc_mem_we", 32'(bus.mem_we), 32'(bus.we & ~m_io));
      chk("cyc_out_ports", 32'(out_ports), 32'(exp_ports()));
      chk("cyc_irq", 32'(irq), 32'(|(m_pend & m_mask)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_WIDTH-1:0] a, input string name, input logic [WIDTH-1:0] exp);
    bus.addr = a;
    #1;
    chk(name, 32'(bus.rdata), 32'(exp));
  endtask

  initial begin
    reset = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.mem_rdata = 16'hBEEF; switches = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_out_ports", 32'(out_ports), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk_en = 1'b1;
    #1 reset = 1'b1;
    cyc(1);

    wr(10'h300, 16'h12AB);
    wr(10'h301, 16'h00CD);
    chk("out_ports_after_writes", 32'(out_ports), 32'hCDAB);
    rd(10'h300, "read_out0", 16'h00AB);

    bus.addr = 10'h010; bus.wdata = 16'h5555; bus.we = 1'b1;
    #1;
    chk("pass_mem_we", 32'(bus.mem_we), 32'h1);
    chk("pass_io_sel", 32'(bus.io_sel), 32'h0);
    chk("pass_rdata", 32'(bus.rdata), 32'hBEEF);
    bus.mem_rdata = 16'h1234;
    #1;
    chk("pass_rdata_follow", 32'(bus.rdata), 32'h1234);
    cyc(1);
    bus.we = 1'b0;
    rd(10'h30F, "unmapped_read", 16'h0000);

    switches = 8'h01;
    cyc(10);
    switches = 8'h00;
    cyc(30);
    rd(10'h308, "bounce_sw", 16'h0000);
    rd(10'h309, "bounce_pend", 16'h0000);

    switches = 8'h01;
    cyc(17);
    rd(10'h308, "sw_edge17", 16'h0000);
    cyc(1);
    rd(10'h308, "sw_edge18", 16'h0001);
    rd(10'h309, "pend_edge18", 16'h0001);
    chk("irq_masked", 32'(irq), 32'h0);

    wr(10'h30A, 16'h0001);
    chk("irq_after_mask", 32'(irq), 32'h1);
    wr(10'h309, 16'h0001);
    rd(10'h309, "pend_w1c", 16'h0000);
    chk("irq_after_w1c", 32'(irq), 32'h0);

    switches = 8'h00;
    cyc(18);
    rd(10'h308, "sw_fall", 16'h0000);
    rd(10'h309, "pend_no_fall", 16'h0000);

    switches = 8'h01;
    cyc(17);
    wr(10'h309, 16'h0001);
    rd(10'h309, "pend_set_wins", 16'h0001);
    rd(10'h308, "sw_rise2", 16'h0001);
    chk("irq_set_wins", 32'(irq), 32'h1);
    cyc(3);
    wr(10'h309, 16'h0001);
    rd(10'h309, "pend_late_w1c", 16'h0000);
    chk("irq_late_w1c", 32'(irq), 32'h0);

    wr(10'h30C, 16'hFFFE);
    rd(10'h30C, "timer_load", 16'hFFFE);
    cyc(1);
    rd(10'h30C, "timer_1", 16'hFFFF);
    cyc(1);
    rd(10'h30C, "timer_2", 16'h0000);
    cyc(1);
    rd(10'h30C, "timer_3", 16'h0001);

    cyc(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
